// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered into the ALU; the result is held until the owning requester takes it.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,

  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_c,
  output logic             resp_err,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,

  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] resp_c_q, resp_c_d;
  logic             resp_err_q, resp_err_d;

  logic             gnt_vld;
  logic             gnt_id;
  logic             op_illegal;
  logic             resp_done;

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt_vld = (state_q == IDLE) && (req0_valid || req1_valid);
    gnt_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  end

  assign req0_ready  = gnt_vld && !gnt_id;
  assign req1_ready  = gnt_vld &&  gnt_id;

  assign op_illegal  = (alu_op_q[2:1] == 2'b11);
  assign resp_done   = (state_q == HOLD) && (id_q ? resp1_ready : resp0_ready);

  assign resp0_valid = (state_q == HOLD) && !id_q;
  assign resp1_valid = (state_q == HOLD) &&  id_q;
  assign resp_c      = resp_c_q;
  assign resp_err    = resp_err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    resp_c_d   = resp_c_q;
    resp_err_d = resp_err_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          id_d    = gnt_id;
          ptr_d   = !gnt_id;
          state_d = EXEC;
          if (gnt_id) begin
            alu_a_d  = req1_a;
            alu_b_d  = req1_b;
            alu_op_d = req1_op;
          end else begin
            alu_a_d  = req0_a;
            alu_b_d  = req0_b;
            alu_op_d = req0_op;
          end
        end
      end
      EXEC: begin
        if (op_illegal) begin
          resp_c_d   = '0;
          resp_err_d = 1'b1;
        end else begin
          resp_c_d   = alu_c;
          resp_err_d = 1'b0;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (resp_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      resp_c_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      resp_c_q   <= resp_c_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ALU on the alu_* bus.
module tb_alu_arbiter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [W-1:0] resp_c;
  logic         resp_err;
  logic [W-1:0] alu_a, alu_b, alu_c;
  logic [2:0]   alu_op;
  logic         busy;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_c(resp_c), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal opcodes return garbage so the bench sees whether it leaks through.
  always_comb begin
    case (alu_op)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b010:  alu_c = alu_a & alu_b;
      3'b011:  alu_c = alu_a | alu_b;
      3'b100:  alu_c = alu_a >> alu_b[4:0];
      3'b101:  alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_c = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    bit          who;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] c;
    logic        err;
  } vec_t;

  // Issues one op from a single requester, starting and ending at posedge+1 in IDLE.
  task automatic run_op(input vec_t v);
    bit got;
    got = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    if (v.who) begin
      req1_a = v.a; req1_b = v.b; req1_op = v.op; req1_valid = 1'b1;
    end else begin
      req0_a = v.a; req0_b = v.b; req0_op = v.op; req0_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((v.who ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_ready", {31'd0, got}, 32'd1);
    check("other_ready", {31'd0, v.who ? req0_ready : req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("exec_busy", {31'd0, busy}, 32'd1);
    check("exec_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("hold_valid", {30'd0, resp1_valid, resp0_valid}, v.who ? 32'd2 : 32'd1);
    check("hold_c", resp_c, v.c);
    check("hold_err", {31'd0, resp_err}, {31'd0, v.err});
    @(posedge clk); #1;
    check("done_busy", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 32'd5,          32'd3,      3'b000, 32'd8,          1'b0};
    vecs[1] = '{1'b1, 32'd0,          32'd1,      3'b001, 32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'd2,      3'b000, 32'd1,          1'b0};
    vecs[3] = '{1'b1, 32'h0000_0F0F,  32'h0000_00FF, 3'b010, 32'h0000_000F, 1'b0};
    vecs[4] = '{1'b0, 32'd7,          32'd9,      3'b110, 32'd0,          1'b1};
    vecs[5] = '{1'b0, 32'd1,          32'd2,      3'b011, 32'd3,          1'b0};
    vecs[6] = '{1'b1, 32'd3,          32'd4,      3'b111, 32'd0,          1'b1};
    vecs[7] = '{1'b1, 32'h8000_0000,  32'd4,      3'b101, 32'hF800_0000,  1'b0};
    vecs[8] = '{1'b1, 32'h4000_0000,  32'd2,      3'b101, 32'h1000_0000,  1'b0};
    vecs[9] = '{1'b0, 32'h8000_0000,  32'd31,     3'b100, 32'd1,          1'b0};

    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    #12;
    check("rst_ctrl", {27'd0, busy, resp1_valid, resp0_valid, req1_ready, req0_ready}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op_err", {28'd0, resp_err, alu_op}, 32'd0);
    check("rst_resp_c", resp_c, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Contention from reset: pointer 0 serves req0, then req1, then req0 again.
    req0_a = 32'd10;   req0_b = 32'd4;    req0_op = 3'b001; req0_valid = 1'b1;
    req1_a = 32'hF0;   req1_b = 32'h3C;   req1_op = 3'b010; req1_valid = 1'b1;
    @(negedge clk);
    check("cont1_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("cont1_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("cont1_valid", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    check("cont1_c", resp_c, 32'd6);
    check("cont1_hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("cont2_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("cont2_valid", {30'd0, resp1_valid, resp0_valid}, 32'd2);
    check("cont2_c", resp_c, 32'h30);
    @(posedge clk); @(negedge clk);
    check("cont3_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("cont3_valid", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    check("cont3_c", resp_c, 32'd6);
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // ALU inputs must keep the last op while idle request inputs toggle.
    for (int i = 0; i < 4; i++) begin
      req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom);
      @(negedge clk);
      check("idle_alu_a", alu_a, 32'h8000_0000);
      check("idle_alu_b", alu_b, 32'd31);
      check("idle_alu_op", {29'd0, alu_op}, 32'd4);
      @(posedge clk); #1;
    end

    // Back-pressure on requester 1 with requester 0 waiting.
    resp1_ready = 1'b0;
    resp0_ready = 1'b1;
    req1_a = 32'h8000_0000; req1_b = 32'd4; req1_op = 3'b101; req1_valid = 1'b1;
    @(negedge clk);
    check("bp_grant", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_a = 32'd2; req0_b = 32'd3; req0_op = 3'b000; req0_valid = 1'b1;
    @(negedge clk);
    check("bp_exec_ready0", {31'd0, req0_ready}, 32'd0);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {30'd0, resp1_valid, resp0_valid}, 32'd2);
      check("bp_hold_c", resp_c, 32'hF800_0000);
      check("bp_hold_ready0", {31'd0, req0_ready}, 32'd0);
      @(posedge clk);
    end
    #1;
    resp1_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, resp1_valid}, 32'd1);
    check("bp_release_ready0", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("bp_after_ready0", {31'd0, req0_ready}, 32'd1);
    check("bp_after_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("bp_req0_c", resp_c, 32'd5);
    check("bp_req0_valid", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    @(posedge clk); #1;

    // Reset during EXEC drops the transaction and clears the pointer.
    req0_a = 32'd5; req0_b = 32'd6; req0_op = 3'b000; req0_valid = 1'b1;
    @(negedge clk);
    check("rmid_grant", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rmid_ctrl", {27'd0, busy, resp1_valid, resp0_valid, req1_ready, req0_ready}, 32'd0);
    check("rmid_alu_a", alu_a, 32'd0);
    check("rmid_alu_b", alu_b, 32'd0);
    check("rmid_op_err", {28'd0, resp_err, alu_op}, 32'd0);
    check("rmid_resp_c", resp_c, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmid_no_resp", {29'd0, busy, resp1_valid, resp0_valid}, 32'd0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_a = 32'd9; req1_b = 32'd4; req1_op = 3'b000; req1_valid = 1'b1;
    #1;
    check("rmid_ptr0", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    #1;
    check("rmid_req1_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check("rmid_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("rmid_req1_valid", {30'd0, resp1_valid, resp0_valid}, 32'd2);
    check("rmid_req1_c", resp_c, 32'd13);
    @(posedge clk); #1;
    check("rmid_done", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
